// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: waits on late load data, extracts byte/half/word and drives the RF write port.
// Optional MISALIGN_TRAP_EN: misaligned half/word loads are dropped and flagged on misalign_err.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rdata_valid,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  load_timeout,
  output logic                  misalign_err
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [1:0]            size;
    logic                  uns;
    logic [1:0]            off;
  } ld_req_t;

  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input logic uns,
                                                input logic [1:0] off, input logic [DATA_W-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = d[16*off[1] +: 16];
    case (size)
      2'b00:   extract = uns ? {{(DATA_W-8){1'b0}}, b}  : {{(DATA_W-8){b[7]}}, b};
      2'b01:   extract = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: extract = d;  // 11 is reserved and behaves as a word
    endcase
  endfunction

  state_t               state;
  ld_req_t              pend, req_c;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    ld_data;
  logic                 ld_mis;
  logic                 ld_we;

  // Load attributes come straight from the inputs on a same-cycle hit, else from the pending capture.
  always_comb begin
    req_c = '{rd: in_rd, reg_write: in_reg_write, size: in_size, uns: in_unsigned,
              off: alu_result[1:0]};
    if (state == WAIT_LOAD) req_c = pend;
  end

  assign ld_data = extract(req_c.size, req_c.uns, req_c.off, mem_rdata);

`ifdef MISALIGN_TRAP_EN
  assign ld_mis = (req_c.size == 2'b01) ? req_c.off[0] :
                  (req_c.size == 2'b00) ? 1'b0 : (req_c.off != 2'b00);
`else
  assign ld_mis = 1'b0;
`endif

  assign ld_we = req_c.reg_write && (req_c.rd != '0) && !ld_mis;

  assign stall_req = !flush && !mem_rdata_valid &&
                     ((state == WAIT_LOAD) || (in_valid && in_is_load));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= '0;
      wb_we        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      load_timeout <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      wb_we        <= 1'b0;
      load_timeout <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            if (!in_is_load) begin
              wb_we   <= in_reg_write && (in_rd != '0);
              wb_addr <= in_rd;
              wb_data <= alu_result;
            end else if (mem_rdata_valid) begin
              wb_we        <= ld_we;
              wb_addr      <= req_c.rd;
              wb_data      <= ld_data;
              misalign_err <= ld_mis;
            end else begin
              pend  <= req_c;
              cnt   <= CNT_W'(1);
              state <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (mem_rdata_valid) begin
            wb_we        <= ld_we;
            wb_addr      <= req_c.rd;
            wb_data      <= ld_data;
            misalign_err <= ld_mis;
            state        <= IDLE;
            cnt          <= '0;
          end else if (cnt == CNT_W'(TIMEOUT-1)) begin
            load_timeout <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vector table plus multi-cycle wait/timeout/flush/reset sequences.
module tb_mem_wb_stage;
  logic        clk, rst;
  logic        in_valid, in_reg_write, in_is_load, in_unsigned;
  logic [1:0]  in_size;
  logic [4:0]  in_rd;
  logic [31:0] alu_result, mem_rdata;
  logic        mem_rdata_valid, flush;
  logic        stall_req, wb_we, load_timeout, misalign_err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

`ifdef MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_is_load(in_is_load), .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .flush(flush), .stall_req(stall_req), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .load_timeout(load_timeout), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw, ld;
    logic [1:0]  sz;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
    logic        rv, fl;
    logic        e_stall, e_we, e_chk;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, rw, ld, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd, input logic [31:0] alu, rdata,
                       input logic rv, fl);
    in_valid = v; in_reg_write = rw; in_is_load = ld; in_size = sz; in_unsigned = uns;
    in_rd = rd; alu_result = alu; mem_rdata = rdata; mem_rdata_valid = rv; flush = fl;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{1,1,0,2'b00,0, 7,32'h1234_5678,32'h0,        0,0, 0,1,1, 7,32'h1234_5678,0};
    vecs[1]  = '{1,1,1,2'b00,0, 8,32'h0000_1003,32'h80AA_BBCC,1,0, 0,1,1, 8,32'hFFFF_FF80,0};
    vecs[2]  = '{1,1,1,2'b00,1, 9,32'h0000_1003,32'h80AA_BBCC,1,0, 0,1,1, 9,32'h0000_0080,0};
    vecs[3]  = '{1,1,1,2'b00,0,10,32'h0000_1001,32'h80AA_BBCC,1,0, 0,1,1,10,32'hFFFF_FFBB,0};
    vecs[4]  = '{1,1,1,2'b00,1,11,32'h0000_1000,32'h80AA_BBCC,1,0, 0,1,1,11,32'h0000_00CC,0};
    vecs[5]  = '{1,1,1,2'b01,0,12,32'h0000_1002,32'h80AA_BBCC,1,0, 0,1,1,12,32'hFFFF_80AA,0};
    vecs[6]  = '{1,1,1,2'b01,1,13,32'h0000_1000,32'h80AA_BBCC,1,0, 0,1,1,13,32'h0000_BBCC,0};
    vecs[7]  = '{1,1,1,2'b10,0,14,32'h0000_1000,32'h80AA_BBCC,1,0, 0,1,1,14,32'h80AA_BBCC,0};
    vecs[8]  = '{1,1,0,2'b00,0, 0,32'hDEAD_BEEF,32'h0,        0,0, 0,0,1, 0,32'hDEAD_BEEF,0};
    vecs[9]  = '{1,0,0,2'b00,0, 5,32'h0000_0055,32'h0,        0,0, 0,0,1, 5,32'h0000_0055,0};
    vecs[10] = '{1,1,0,2'b00,0,12,32'h1111_1111,32'h0,        0,1, 0,0,1, 5,32'h0000_0055,0};
    vecs[11] = '{0,1,0,2'b00,0,12,32'h2222_2222,32'h0,        0,0, 0,0,1, 5,32'h0000_0055,0};
    vecs[12] = '{1,1,1,2'b10,0,20,32'h0000_1000,32'h0,        0,1, 0,0,1, 5,32'h0000_0055,0};
    vecs[13] = '{1,1,1,2'b10,0,13,32'h0000_1001,32'h0102_0304,1,0, 0,!MIS_EN,!MIS_EN,13,32'h0102_0304,MIS_EN};
    vecs[14] = '{1,1,1,2'b11,0,14,32'h0000_1000,32'hCAFE_F00D,1,0, 0,1,1,14,32'hCAFE_F00D,0};
    vecs[15] = '{1,1,0,2'b00,0,31,32'hA5A5_A5A5,32'h0,        0,0, 0,1,1,31,32'hA5A5_A5A5,0};

    rst = 1'b1;
    drive(0,0,0,2'b00,0,0,32'h0,32'h0,0,0);
    #12;
    chk("reset wb_we", {31'b0, wb_we}, 32'h0);
    chk("reset wb_addr", {27'b0, wb_addr}, 32'h0);
    chk("reset wb_data", wb_data, 32'h0);
    chk("reset load_timeout", {31'b0, load_timeout}, 32'h0);
    chk("reset misalign_err", {31'b0, misalign_err}, 32'h0);
    chk("reset stall_req", {31'b0, stall_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle transactions, all retiring (or dropped) without entering the wait state
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].ld, vecs[i].sz, vecs[i].uns, vecs[i].rd,
            vecs[i].alu, vecs[i].rdata, vecs[i].rv, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d stall_req", i), {31'b0, stall_req}, {31'b0, vecs[i].e_stall});
      cyc();
      chk($sformatf("vec%0d wb_we", i), {31'b0, wb_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("vec%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_mis});
      chk($sformatf("vec%0d load_timeout", i), {31'b0, load_timeout}, 32'h0);
      if (vecs[i].e_chk) begin
        chk($sformatf("vec%0d wb_addr", i), {27'b0, wb_addr}, {27'b0, vecs[i].e_addr});
        chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
      end
    end

    // Half load, signed, offset 2, data three cycles late
    n = 0;
    drive(1,1,1,2'b01,0,17,32'h0000_2002,32'h0,0,0);
    #1; if (stall_req) n++;
    cyc(); in_valid = 1'b0;
    #1; if (stall_req) n++;
    chk("late half wb_we while waiting", {31'b0, wb_we}, 32'h0);
    cyc();
    #1; if (stall_req) n++;
    cyc();
    mem_rdata = 32'h80AA_BBCC; mem_rdata_valid = 1'b1;
    #1;
    chk("late half stall drops with data", {31'b0, stall_req}, 32'h0);
    chk("late half stall cycles", n, 3);
    cyc();
    mem_rdata_valid = 1'b0;
    chk("late half wb_we", {31'b0, wb_we}, 32'h1);
    chk("late half wb_addr", {27'b0, wb_addr}, 32'd17);
    chk("late half wb_data", wb_data, 32'hFFFF_80AA);
    cyc();
    chk("late half wb_we one-cycle", {31'b0, wb_we}, 32'h0);

    // No response: timeout after TIMEOUT-1 waiting cycles
    drive(1,1,1,2'b10,0,15,32'h0000_3000,32'h0,0,0);
    #1;
    chk("timeout accept stall", {31'b0, stall_req}, 32'h1);
    cyc(); in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!stall_req) break;
      n++;
      if (load_timeout !== 1'b0 || wb_we !== 1'b0) chk("timeout early pulse/write", {30'b0, load_timeout, wb_we}, 32'h0);
      cyc();
    end
    chk("timeout wait cycles", n, 15);
    chk("timeout pulse", {31'b0, load_timeout}, 32'h1);
    chk("timeout wb_we", {31'b0, wb_we}, 32'h0);
    cyc();
    drive(1,1,0,2'b00,0,3,32'h0000_0077,32'h0,0,0);
    #1;
    chk("after timeout stall", {31'b0, stall_req}, 32'h0);
    chk("timeout pulse one-cycle", {31'b0, load_timeout}, 32'h0);
    cyc(); in_valid = 1'b0;
    chk("after timeout alu wb_we", {31'b0, wb_we}, 32'h1);
    chk("after timeout alu wb_data", wb_data, 32'h0000_0077);

    // Flush in WAIT_LOAD together with data valid
    drive(1,1,1,2'b10,0,16,32'h0000_4000,32'h0,0,0);
    cyc(); in_valid = 1'b0;
    flush = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    #1;
    chk("flush wait stall", {31'b0, stall_req}, 32'h0);
    cyc();
    flush = 1'b0; mem_rdata_valid = 1'b0;
    chk("flush wait wb_we", {31'b0, wb_we}, 32'h0);
    chk("flush wait load_timeout", {31'b0, load_timeout}, 32'h0);
    chk("flush wait wb_data held", wb_data, 32'h0000_0077);
    #1;
    chk("flush wait back to idle", {31'b0, stall_req}, 32'h0);

    // Asynchronous reset while waiting
    drive(1,1,1,2'b10,0,18,32'h0000_5000,32'h0,0,0);
    cyc(); in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid-wait rst wb_addr", {27'b0, wb_addr}, 32'h0);
    chk("mid-wait rst wb_data", wb_data, 32'h0);
    chk("mid-wait rst stall", {31'b0, stall_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1,1,0,2'b00,0,4,32'h0000_0099,32'h0,0,0);
    cyc(); in_valid = 1'b0;
    chk("post-rst alu wb_we", {31'b0, wb_we}, 32'h1);
    chk("post-rst alu wb_addr", {27'b0, wb_addr}, 32'd4);
    chk("post-rst alu wb_data", wb_data, 32'h0000_0099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
